// File: rtl/data_memory_responder.sv
// Byte-addressed, big-endian data memory for the MEM stage. It answers each
// accepted request after WAIT_STATES extra cycles and drives a combinational stall back to the pipeline.
`timescale 1ns/1ps
module data_memory_responder #(
   parameter int ADDR_WIDTH  = 9,
   parameter int WAIT_STATES = 2
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  mem_enable,
   input  logic                  mem_readwrite,
   input  logic [1:0]            mem_size,
   input  logic                  mem_signe,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           write_data,
   output logic [31:0]           read_data,
   output logic                  mem_busy,
   output logic                  mem_done,
   output logic                  align_error
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [3:0]            r_count;
   logic                  r_rw;
   logic                  r_signe;
   logic [1:0]            r_size;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [7:0]            r_mem [DEPTH];

   logic                  w_misaligned;
   logic                  w_accept;
   logic                  w_reject;
   logic                  w_access;
   logic [ADDR_WIDTH-1:0] w_a1;
   logic [ADDR_WIDTH-1:0] w_a2;
   logic [ADDR_WIDTH-1:0] w_a3;
   logic [7:0]            w_b0;
   logic [7:0]            w_b1;
   logic [7:0]            w_b2;
   logic [7:0]            w_b3;
   logic [31:0]           w_load_data;

   always_comb begin
      case (mem_size)
         2'b00:   w_misaligned = 1'b0;
         2'b01:   w_misaligned = address[0];
         2'b10:   w_misaligned = (address[1:0] != 2'b00);
         default: w_misaligned = 1'b1;
      endcase
   end

   // mem_done gates acceptance: the completed request is still presented for one more cycle.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      w_access     = 1'b0;
      mem_busy     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (mem_enable && !mem_done) begin
               mem_busy = 1'b1;
               if (w_misaligned) begin
                  w_reject = 1'b1;
               end else begin
                  w_accept     = 1'b1;
                  w_next_state = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            mem_busy = 1'b1;
            if (r_count == 4'd0) begin
               w_access     = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_count     <= 4'd0;
         read_data   <= 32'd0;
         mem_done    <= 1'b0;
         align_error <= 1'b0;
      end else begin
         mem_done    <= w_access | w_reject;
         align_error <= w_reject;
         if (w_accept)
            r_count <= 4'(WAIT_STATES);
         else if (r_state == ST_WAIT && r_count != 4'd0)
            r_count <= r_count - 4'd1;
         if (w_access && !r_rw)
            read_data <= w_load_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (w_accept) begin
         r_rw    <= mem_readwrite;
         r_size  <= mem_size;
         r_signe <= mem_signe;
         r_addr  <= address;
         r_wdata <= write_data;
      end
   end

   assign w_a1 = r_addr + ADDR_WIDTH'(1);
   assign w_a2 = r_addr + ADDR_WIDTH'(2);
   assign w_a3 = r_addr + ADDR_WIDTH'(3);
   assign w_b0 = r_mem[r_addr];
   assign w_b1 = r_mem[w_a1];
   assign w_b2 = r_mem[w_a2];
   assign w_b3 = r_mem[w_a3];

   always_comb begin
      case (r_size)
         2'b00:   w_load_data = r_signe ? {{24{w_b0[7]}}, w_b0} : {24'd0, w_b0};
         2'b01:   w_load_data = r_signe ? {{16{w_b0[7]}}, w_b0, w_b1} : {16'd0, w_b0, w_b1};
         default: w_load_data = {w_b0, w_b1, w_b2, w_b3};
      endcase
   end

   // A reset landing on the access edge must still suppress the write.
   always_ff @(posedge Clk) begin
      if (!Reset && w_access && r_rw) begin
         case (r_size)
            2'b00: r_mem[r_addr] <= r_wdata[7:0];
            2'b01: begin
               r_mem[r_addr] <= r_wdata[15:8];
               r_mem[w_a1]   <= r_wdata[7:0];
            end
            2'b10: begin
               r_mem[r_addr] <= r_wdata[31:24];
               r_mem[w_a1]   <= r_wdata[23:16];
               r_mem[w_a2]   <= r_wdata[15:8];
               r_mem[w_a3]   <= r_wdata[7:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with two wait states,
// one with none, sharing request inputs but with separate enables.
`timescale 1ns/1ps
module tb_data_memory_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        sel;
   logic        rw;
   logic [1:0]  sz;
   logic        se;
   logic [8:0]  addr;
   logic [31:0] wd;

   logic        en2, en0;
   logic [31:0] rd2, rd0;
   logic        busy2, busy0, done2, done0, err2, err0;
   logic [31:0] rd_s;
   logic        busy_s, done_s, err_s;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign en2    = en & ~sel;
   assign en0    = en & sel;
   assign rd_s   = sel ? rd0   : rd2;
   assign busy_s = sel ? busy0 : busy2;
   assign done_s = sel ? done0 : done2;
   assign err_s  = sel ? err0  : err2;

   data_memory_responder #(.ADDR_WIDTH(9), .WAIT_STATES(2)) dut2 (
      .Clk(clk), .Reset(rst), .mem_enable(en2), .mem_readwrite(rw),
      .mem_size(sz), .mem_signe(se), .address(addr), .write_data(wd),
      .read_data(rd2), .mem_busy(busy2), .mem_done(done2), .align_error(err2)
   );

   data_memory_responder #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
      .Clk(clk), .Reset(rst), .mem_enable(en0), .mem_readwrite(rw),
      .mem_size(sz), .mem_signe(se), .address(addr), .write_data(wd),
      .read_data(rd0), .mem_busy(busy0), .mem_done(done0), .align_error(err0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Presents one request at the start of a cycle and holds it through the done cycle.
   task automatic req(input logic rw_i, input logic [1:0] sz_i, input logic se_i,
                      input logic [8:0] a_i, input logic [31:0] wd_i,
                      input int exp_done, input logic exp_err, input logic [31:0] exp_rd,
                      input bit keep, input string tag);
      int          done_cyc;
      int          busy_n;
      logic        busy_at_done;
      logic        err_at_done;
      logic [31:0] rd_at_done;
      rw = rw_i; sz = sz_i; se = se_i; addr = a_i; wd = wd_i; en = 1'b1;
      done_cyc = -1; busy_n = 0; busy_at_done = 1'b1; err_at_done = 1'b0; rd_at_done = 32'd0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_s) begin
            done_cyc     = c;
            busy_at_done = busy_s;
            err_at_done  = err_s;
            rd_at_done   = rd_s;
         end else if (busy_s) begin
            busy_n++;
         end
         @(posedge clk); #1;
         if (done_cyc >= 0) break;
      end
      chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
      chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_done));
      chk({tag, "_busy_in_done"}, {31'd0, busy_at_done}, 32'd0);
      chk({tag, "_align_error"}, {31'd0, err_at_done}, {31'd0, exp_err});
      chk({tag, "_read_data"}, rd_at_done, exp_rd);
      if (!keep) begin
         en = 1'b0;
         @(negedge clk);
         chk({tag, "_done_single"}, {31'd0, done_s}, 32'd0);
         chk({tag, "_err_single"}, {31'd0, err_s}, 32'd0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      bit saw_done;
      rst = 1'b1; en = 1'b0; sel = 1'b0; rw = 1'b0; sz = 2'b00; se = 1'b0;
      addr = 9'd0; wd = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rd2", rd2, 32'd0);
      chk("rst_done2", {31'd0, done2}, 32'd0);
      chk("rst_err2", {31'd0, err2}, 32'd0);
      chk("rst_busy2", {31'd0, busy2}, 32'd0);
      chk("rst_rd0", rd0, 32'd0);
      chk("rst_done0", {31'd0, done0}, 32'd0);
      @(posedge clk); #1;

      // Reset while a store is waiting: no write, no done pulse.
      req(1'b1, 2'b10, 1'b0, 9'h020, 32'h11223344, 4, 1'b0, 32'd0, 1'b0, "st_pre");
      rw = 1'b1; sz = 2'b10; addr = 9'h020; wd = 32'hAABBCCDD; en = 1'b1;
      @(negedge clk);
      chk("abort_busy_c0", {31'd0, busy2}, 32'd1);
      @(posedge clk); #1;
      en = 1'b0;
      @(negedge clk);
      chk("abort_busy_c1", {31'd0, busy2}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      saw_done = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done2) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      chk("abort_no_done", {31'd0, saw_done}, 32'd0);
      chk("abort_rd", rd2, 32'd0);
      chk("abort_busy", {31'd0, busy2}, 32'd0);
      req(1'b0, 2'b10, 1'b0, 9'h020, 32'd0, 4, 1'b0, 32'h11223344, 1'b0, "ld_after_abort");

      // Word round trip and sub-word loads.
      req(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 4, 1'b0, 32'h11223344, 1'b0, "st_word");
      req(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 4, 1'b0, 32'hDEADBEEF, 1'b0, "ld_word");
      req(1'b0, 2'b00, 1'b1, 9'h010, 32'd0, 4, 1'b0, 32'hFFFFFFDE, 1'b0, "ld_byte_sx");
      req(1'b0, 2'b00, 1'b0, 9'h010, 32'd0, 4, 1'b0, 32'h000000DE, 1'b0, "ld_byte_zx");
      req(1'b0, 2'b01, 1'b1, 9'h012, 32'd0, 4, 1'b0, 32'hFFFFBEEF, 1'b0, "ld_half_sx");
      req(1'b0, 2'b01, 1'b0, 9'h010, 32'd0, 4, 1'b0, 32'h0000DEAD, 1'b0, "ld_half_zx");

      // Byte store touches only its own byte.
      req(1'b1, 2'b00, 1'b1, 9'h011, 32'hFFFFFF7A, 4, 1'b0, 32'h0000DEAD, 1'b0, "st_byte");
      req(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 4, 1'b0, 32'hDE7ABEEF, 1'b0, "ld_merge");

      // Misaligned and illegal-size requests.
      req(1'b0, 2'b10, 1'b0, 9'h013, 32'd0, 1, 1'b1, 32'hDE7ABEEF, 1'b0, "mis_word_ld");
      req(1'b0, 2'b01, 1'b0, 9'h001, 32'd0, 1, 1'b1, 32'hDE7ABEEF, 1'b0, "mis_half_ld");
      req(1'b0, 2'b11, 1'b0, 9'h000, 32'd0, 1, 1'b1, 32'hDE7ABEEF, 1'b0, "mis_size_ld");
      req(1'b1, 2'b11, 1'b0, 9'h010, 32'h00000000, 1, 1'b1, 32'hDE7ABEEF, 1'b0, "mis_size_st");
      req(1'b1, 2'b10, 1'b0, 9'h012, 32'h00000000, 1, 1'b1, 32'hDE7ABEEF, 1'b0, "mis_word_st");
      req(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 4, 1'b0, 32'hDE7ABEEF, 1'b0, "ld_after_mis");

      // Enable held through completion, next request follows after the bubble.
      req(1'b1, 2'b10, 1'b0, 9'h040, 32'hCAFEF00D, 4, 1'b0, 32'hDE7ABEEF, 1'b1, "b2b_st");
      req(1'b0, 2'b10, 1'b0, 9'h040, 32'd0, 4, 1'b0, 32'hCAFEF00D, 1'b0, "b2b_ld");

      // Zero wait states, top of memory.
      sel = 1'b1;
      req(1'b1, 2'b10, 1'b0, 9'h1FC, 32'h89ABCDEF, 2, 1'b0, 32'd0, 1'b1, "ws0_st_top");
      req(1'b0, 2'b10, 1'b0, 9'h1FC, 32'd0, 2, 1'b0, 32'h89ABCDEF, 1'b0, "ws0_ld_top");
      req(1'b0, 2'b00, 1'b1, 9'h1FF, 32'd0, 2, 1'b0, 32'hFFFFFFEF, 1'b0, "ws0_ld_byte");
      req(1'b0, 2'b01, 1'b0, 9'h1FE, 32'd0, 2, 1'b0, 32'h0000CDEF, 1'b0, "ws0_ld_half");
      req(1'b0, 2'b01, 1'b0, 9'h1FF, 32'd0, 1, 1'b1, 32'h0000CDEF, 1'b0, "ws0_mis_half");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Data-memory target for the MEM stage. Consumes the EX/MEM request bundle (enable, read/write, size, sign-extend, 9-bit address, store data) and returns load data after a configurable number of wait states. Drives a combinational busy/stall signal back to the pipeline. Memory is byte-addressed, big-endian, and supports byte, halfword and word accesses.

Parameters:
ADDR_WIDTH, 9, byte address width; DEPTH = 2**ADDR_WIDTH bytes
WAIT_STATES, 2, extra cycles per access, legal range 0..15

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  synchronous, active-high reset
mem_enable  input  1  request valid (EX/MEM MEM_ENABLE)
mem_readwrite  input  1  0 = load (read), 1 = store (write)
mem_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
mem_signe  input  1  loads only: 1 = sign-extend, 0 = zero-extend
address  input  ADDR_WIDTH  byte address
write_data  input  32  store data, right-justified
read_data  output  32  registered load result
mem_busy  output  1  combinational stall request to the pipeline
mem_done  output  1  registered one-cycle completion pulse
align_error  output  1  registered one-cycle pulse, coincident with mem_done

Behaviour:
- Clock is Clk. Reset is synchronous and active-high, sampled on the rising edge of Clk.
- Reset values: state=IDLE, wait counter=0, read_data=0, mem_done=0, align_error=0. The memory array is not cleared.
- Reset during WAIT aborts the access: no write occurs and no done pulse is issued.
- FSM has two states, IDLE and WAIT.
- IDLE: a request is accepted at an edge when mem_enable=1 and mem_done=0.
  - mem_done=1 blocks acceptance because the stalled request is still held one cycle after completion. This costs one bubble between back-to-back requests.
  - On acceptance, latch readwrite, size, signe, address and write_data. Load counter with WAIT_STATES. Go to WAIT.
- Alignment check at acceptance:
  - Halfword requires address[0]=0.
  - Word requires address[1:0]=00.
  - mem_size=11 is always an error.
  - On error: stay in IDLE, set mem_done=1 and align_error=1 for one cycle, perform no memory access, leave read_data unchanged.
- WAIT:
  - If counter≠0 at an edge, decrement it.
  - If counter=0 at an edge, perform the access, pulse mem_done for one cycle, and return to IDLE.
  - Inputs that change during WAIT are ignored; latched values are used.
- Timing: request presented in cycle 0 and accepted at edge E0.
  - Access occurs at edge E(WAIT_STATES+1).
  - mem_done is high in cycle WAIT_STATES+2.
- mem_busy = (state=WAIT) OR (state=IDLE AND mem_enable AND NOT mem_done).
  - Busy is high from the presentation cycle until mem_done rises, and low in the mem_done cycle.
  - For a misaligned request, busy is high only in cycle 0.
- Store, big-endian, with a = latched address:
  - Byte: mem[a] <= wd[7:0].
  - Halfword: mem[a] <= wd[15:8], mem[a+1] <= wd[7:0].
  - Word: mem[a..a+3] <= wd[31:24], wd[23:16], wd[15:8], wd[7:0].
  - read_data is unchanged on a store.
- Load:
  - Byte: read_data = ext(mem[a]).
  - Halfword: read_data = ext({mem[a], mem[a+1]}).
  - Word: read_data = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
  - ext sign-extends if the latched signe=1, otherwise zero-extends. mem_signe is ignored for words and stores.
- Address arithmetic is modulo DEPTH. Aligned accesses never wrap.
- The top of memory is legal: a word load at address 0x1FC reads bytes 0x1FC..0x1FF.
- mem_done and align_error are never high for more than one consecutive cycle.

Test Plan:
1. Reset mid-operation: after a store is accepted, assert Reset in WAIT → no done pulse; a later load of the same address returns the prior contents; outputs are 0 after reset.
2. WAIT_STATES=2: store word 0xDEADBEEF at 0x010, then load word at 0x010 → mem_busy high 4 cycles, mem_done in cycle 4, read_data=0xDEADBEEF.
3. After scenario 2: load byte at 0x010 with signe=1 → 0xFFFFFFDE; signe=0 → 0x000000DE; load halfword at 0x012 with signe=1 → 0xFFFFBEEF.
4. Store byte 0x7A at 0x011 over 0xDEADBEEF, then load word 0x010 → 0xDE7ABEEF; the three other bytes are unchanged.
5. Misalignment: word load at 0x013, halfword at 0x001, size=11 at 0x000 → each gives done=align_error=1 the next cycle, busy 1 cycle, read_data unchanged, memory unchanged.
6. mem_enable held high through completion, then a second request follows → exactly one access per request with one bubble cycle. With WAIT_STATES=0: done in cycle 2, busy 2 cycles; word at 0x1FC round-trips correctly.
